// File: rtl/track_ctrl_pkg.sv
// Shared types and default constants for the track position sequencer.
package track_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN_FWD,
        RUN_BACK,
        HOMING,
        SETTLE
    } track_state_e;

    localparam int TICK_CYCLES_DFLT  = 500000;
    localparam int POS_W_DFLT        = 8;
    localparam int MAX_POS_DFLT      = 200;
    localparam int HOME_TIMEOUT_DFLT = MAX_POS_DFLT + 16;

endpackage

// File: rtl/track_seq_ctrl_if.sv
// Command handshake, switch/abort inputs and driver/status outputs of the track sequencer.
interface track_seq_ctrl_if
    import track_ctrl_pkg::*;
#(
    parameter int POS_W = POS_W_DFLT
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_home_i;
    logic [POS_W-1:0] cmd_pos_i;
    logic             home_sw_i;
    logic             abort_i;
    logic             move_o;
    logic             back_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [POS_W-1:0] pos_o;
    logic             homed_o;

    modport slave (
        input  cmd_valid_i, cmd_home_i, cmd_pos_i, home_sw_i, abort_i,
        output cmd_ready_o, move_o, back_o, busy_o, done_o, err_o, pos_o, homed_o
    );

    modport master (
        output cmd_valid_i, cmd_home_i, cmd_pos_i, home_sw_i, abort_i,
        input  cmd_ready_o, move_o, back_o, busy_o, done_o, err_o, pos_o, homed_o
    );
endinterface

// File: rtl/track_seq_ctrl_step_tick_gen.sv
// Step-period tick: one-cycle pulse every TICK_CYCLES clocks, restarted by clr.
module step_tick_gen
    import track_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded from the register only, so the FSM may use clr = f(tick) safely.
    assign tick = (cnt == LAST);
endmodule

// File: rtl/track_seq_ctrl.sv
// Track stepper position sequencer: homing, open-loop moves, abort and settle.
//   state    | meaning
//   IDLE     | ready for a command, no motion
//   RUN_FWD  | stepping away from home, pos +1 per tick
//   RUN_BACK | stepping toward home, pos -1 per tick
//   HOMING   | stepping toward home until the limit switch or timeout
//   SETTLE   | motion stopped, wait one step period before done
module track_seq_ctrl
    import track_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_CYCLES_DFLT,
    parameter int POS_W        = POS_W_DFLT,
    parameter int MAX_POS      = MAX_POS_DFLT,
    parameter int HOME_TIMEOUT = HOME_TIMEOUT_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    track_seq_ctrl_if.slave  bus
);
    localparam int TO_W = $clog2(HOME_TIMEOUT + 1);
    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX_POS);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(HOME_TIMEOUT);

    track_state_e     state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, tgt_q, tgt_d, pos_step;
    logic [TO_W-1:0]  to_q, to_d;
    logic             move_q, move_d, back_q, back_d, done_q, done_d;
    logic             err_q, err_d, homed_q, homed_d;
    logic             tick, tick_clr;

    step_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign tick_clr = (state_q == IDLE) || (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            to_q    <= '0;
            move_q  <= 1'b0;
            back_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            homed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            to_q    <= to_d;
            move_q  <= move_d;
            back_q  <= back_d;
            done_q  <= done_d;
            err_q   <= err_d;
            homed_q <= homed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        to_d     = to_q;
        back_d   = back_q;
        done_d   = 1'b0;
        err_d    = err_q;
        homed_d  = homed_q;
        pos_step = '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    err_d = 1'b0;
                    tgt_d = bus.cmd_pos_i;
                    if (bus.cmd_home_i) begin
                        if (bus.home_sw_i) begin
                            pos_d   = '0;
                            homed_d = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            state_d = HOMING;
                            to_d    = TO_LOAD;
                            back_d  = 1'b1;
                        end
                    end else if (!homed_q || bus.cmd_pos_i > MAX_P) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (bus.cmd_pos_i == pos_q) begin
                        done_d = 1'b1;
                    end else if (bus.cmd_pos_i > pos_q) begin
                        state_d = RUN_FWD;
                        back_d  = 1'b0;
                    end else begin
                        state_d = RUN_BACK;
                        back_d  = 1'b1;
                    end
                end
            end
            RUN_FWD: begin
                pos_step = pos_q + 1'b1;
                if (tick) begin
                    pos_d = pos_step;
                    if (pos_step == tgt_q) state_d = SETTLE;
                end
                if (bus.abort_i) begin
                    state_d = SETTLE;
                    err_d   = 1'b1;
                end
            end
            RUN_BACK: begin
                pos_step = pos_q - 1'b1;
                if (tick) pos_d = pos_step;
                if (tick && pos_step == tgt_q) begin
                    state_d = SETTLE;
                end else if (bus.home_sw_i) begin
                    // Switch hit before the target: the count had drifted, re-anchor at 0.
                    pos_d   = '0;
                    err_d   = 1'b1;
                    state_d = SETTLE;
                end
                if (bus.abort_i) begin
                    state_d = SETTLE;
                    err_d   = 1'b1;
                end
            end
            HOMING: begin
                if (bus.home_sw_i) begin
                    pos_d   = '0;
                    homed_d = 1'b1;
                    state_d = SETTLE;
                end else begin
                    if (tick) begin
                        to_d = to_q - 1'b1;
                        if (to_q == TO_W'(1)) begin
                            homed_d = 1'b0;
                            err_d   = 1'b1;
                            state_d = SETTLE;
                        end
                    end
                    if (bus.abort_i) begin
                        homed_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (tick) begin
                    done_d  = 1'b1;
                    back_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        move_d = (state_d == RUN_FWD) || (state_d == RUN_BACK) || (state_d == HOMING);
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.move_o      = move_q;
    assign bus.back_o      = back_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.pos_o       = pos_q;
    assign bus.homed_o     = homed_q;
endmodule

// File: tb/tb_track_seq_ctrl.sv
// Self-checking bench for track_seq_ctrl: directed scenarios plus random commands vs a timing model.
module tb_track_seq_ctrl;
    localparam int T    = 10;
    localparam int PW   = 8;
    localparam int MAXP = 200;
    localparam int HT   = 216;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    track_seq_ctrl_if #(.POS_W(PW)) bus ();

    track_seq_ctrl #(
        .TICK_CYCLES (T),
        .POS_W       (PW),
        .MAX_POS     (MAXP),
        .HOME_TIMEOUT(HT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_cmd = 0;
    int m_pos = 0;
    bit m_homed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {ready, busy, move, back, done, err, homed, pos}
    function automatic logic [31:0] obs_vec();
        return {17'd0, bus.cmd_ready_o, bus.busy_o, bus.move_o, bus.back_o,
                bus.done_o, bus.err_o, bus.homed_o, bus.pos_o};
    endfunction

    function automatic logic [31:0] mk_vec(input bit rdy, input bit bsy, input bit mv, input bit bk,
                                           input bit dn, input bit er, input bit hm, input int p);
        return {17'd0, rdy, bsy, mv, bk, dn, er, hm, 8'(p)};
    endfunction

    // s: -1 switch already high at accept, 0 never, >0 raised for edge s after accept.
    // a: 0 no abort, >0 abort seen at edge a after accept. bp: poke cmd_valid while busy.
    task automatic run_cmd(input bit home, input int p, input int s, input int a, input bit bp);
        int ev, len, pos_f, dir, cur, vb, d;
        bit err_f, homed_f, bk;
        dir = 0; bk = 1'b0; pos_f = m_pos; homed_f = m_homed; err_f = 1'b0; ev = 0;
        if (home) begin
            if (s < 0) begin
                pos_f = 0; homed_f = 1'b1;
            end else begin
                bk = 1'b1; ev = HT * T; err_f = 1'b1; homed_f = 1'b0;
                if (s > 0 && (a == 0 || s < a) && s < ev) begin
                    ev = s; err_f = 1'b0; homed_f = 1'b1; pos_f = 0;
                end else if (a > 0 && a < ev) begin
                    ev = a;
                end
            end
        end else if (!m_homed || p > MAXP) begin
            err_f = 1'b1;
        end else if (p != m_pos) begin
            dir = (p > m_pos) ? 1 : -1;
            bk = (p < m_pos);
            d = (p > m_pos) ? p - m_pos : m_pos - p;
            ev = d * T; pos_f = p;
            if (a > 0) begin
                ev = a; err_f = 1'b1; pos_f = m_pos + dir * (a / T);
            end else if (s > 0 && bk) begin
                ev = s; err_f = 1'b1; pos_f = 0;
            end
        end
        len = (ev == 0) ? 0 : ev + T;
        vb = (bp && len > 0) ? int'($urandom_range(len - 1, 0)) : -1;

        bus.cmd_valid_i = 1'b1;
        bus.cmd_home_i  = home;
        bus.cmd_pos_i   = 8'(p);
        if (s < 0) bus.home_sw_i = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            cur = (i < ev) ? m_pos + dir * (i / T) : pos_f;
            chk($sformatf("cmd%0d_t%0d", n_cmd, i), obs_vec(),
                mk_vec(i == len, i < len, i < ev, (i < len) ? bk : 1'b0, i == len,
                       (i < ev) ? 1'b0 : err_f, (i < ev) ? m_homed : homed_f, cur));
            bus.cmd_valid_i = (i == vb);
            if (i == vb) begin
                bus.cmd_home_i = 1'($urandom_range(1, 0));
                bus.cmd_pos_i  = 8'($urandom_range(255, 0));
            end
            bus.abort_i = (a > 0 && i == a - 1);
            if (s > 0 && i == s - 1) bus.home_sw_i = 1'b1;
            if (i == len) bus.home_sw_i = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("cmd%0d_idle", n_cmd), obs_vec(), mk_vec(1, 0, 0, 0, 0, err_f, homed_f, pos_f));
        m_pos = pos_f;
        m_homed = homed_f;
        n_cmd++;
    endtask

    initial begin
        int kind, p, s, a, d, r;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_home_i  = 1'b0;
        bus.cmd_pos_i   = '0;
        bus.home_sw_i   = 1'b0;
        bus.abort_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_reset", obs_vec(), mk_vec(1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", obs_vec(), mk_vec(1, 0, 0, 0, 0, 0, 0, 0));

        run_cmd(0, 5, 0, 0, 0);        // not homed: rejected
        run_cmd(1, 0, 25, 0, 1);       // home, switch after 25 cycles
        run_cmd(0, 4, 0, 0, 0);
        run_cmd(0, 1, 0, 0, 0);
        run_cmd(0, 1, 0, 0, 0);        // already there
        run_cmd(0, 10, 0, 23, 0);      // abort after 2nd tick -> pos 3
        run_cmd(0, 3, 0, 0, 0);        // clears err
        run_cmd(0, 201, 0, 0, 0);      // out of range
        run_cmd(1, 0, 0, 0, 1);        // switch stuck low: timeout
        run_cmd(1, 0, 40, 12, 0);      // abort while homing
        run_cmd(1, 0, -1, 0, 0);       // already on switch
        run_cmd(0, 6, 0, 0, 1);
        run_cmd(0, 2, 15, 0, 0);       // switch hit early on the way back
        run_cmd(0, MAXP, 0, 0, 1);     // upper boundary
        run_cmd(0, 0, 0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(9, 0));
            s = 0; a = 0;
            if (kind <= 1) begin
                p = int'($urandom_range(255, 0));
                if ($urandom_range(2, 0) == 0) begin
                    s = -1;
                end else begin
                    s = int'($urandom_range(60, 1));
                    if (s > 1 && $urandom_range(3, 0) == 0) a = int'($urandom_range(s - 1, 1));
                end
                run_cmd(1, p, s, a, 1);
            end else if (kind == 2) begin
                run_cmd(0, int'($urandom_range(255, 201)), 0, 0, 1);
            end else begin
                p = int'($urandom_range(30, 0));
                d = (p > m_pos) ? p - m_pos : m_pos - p;
                if (m_homed && d > 0) begin
                    r = int'($urandom_range(5, 0));
                    if (r == 0) a = int'($urandom_range(d * T - 1, 1));
                    else if (r == 1 && p < m_pos) s = int'($urandom_range(d * T - 1, 1));
                end
                run_cmd(0, p, s, a, 1);
            end
        end

        // Reset in the middle of a move must drop move_o without waiting for a clock.
        run_cmd(1, 0, -1, 0, 0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_home_i  = 1'b0;
        bus.cmd_pos_i   = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("moving_before_rst", obs_vec(), mk_vec(0, 1, 1, 0, 0, 0, 1, 1));
        #2 rst_n = 1'b0;
        #1 chk("async_rst", obs_vec(), mk_vec(1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_release", obs_vec(), mk_vec(1, 0, 0, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/track_seq_ctrl.md
Name: track_seq_ctrl

Overview:
Position sequencer for the track stepper driver. It accepts "home" and "go to position N" commands from the top-level kitchen controller over a valid/ready handshake. It drives the driver's move/back enables and keeps an open-loop step count, timed by a tick that matches the driver's step period. The home limit switch provides the absolute reference; completion is reported with a done pulse and an error flag.

Parameters:
TICK_CYCLES, 500000, clk cycles per track step (one full driver step period at 50 MHz, 10 ms setting); sims use 10
POS_W, 8, width of position values
MAX_POS, 200, largest legal target position (steps from home)
HOME_TIMEOUT, 216, max ticks spent homing before error (MAX_POS+16)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  high only in IDLE; command accepted when valid&ready
cmd_home_i  in  1  1 = home command, 0 = position command (sampled at accept)
cmd_pos_i  in  POS_W  target position (sampled at accept, ignored for home)
home_sw_i  in  1  home limit switch, high at position 0 (pre-synchronised)
abort_i  in  1  stop immediately
move_o  out  1  to driver move_i
back_o  out  1  to driver back_i (1 = toward home)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of every accepted command
err_o  out  1  set at failed command end, cleared on next accept
pos_o  out  POS_W  current position estimate
homed_o  out  1  position reference valid

Behaviour:
- Reset: state IDLE; move_o, back_o, busy_o, done_o, err_o, homed_o = 0; pos_o = 0. cmd_ready_o is 1 after reset. Reset mid-motion drops move_o asynchronously.
- States: IDLE, RUN_FWD, RUN_BACK, HOMING, SETTLE.
- Tick: counter cleared on entry to RUN_FWD/RUN_BACK/HOMING/SETTLE. Tick pulse when count == TICK_CYCLES-1, then wraps to 0. Counter is held at 0 in IDLE.
- Accept in IDLE clears err_o; next state decided the same cycle:
  - Position command, homed_o=0 or cmd_pos_i>MAX_POS: err_o=1, done_o pulses next cycle, stays IDLE, no motion.
  - Position command, cmd_pos_i==pos_o: done_o next cycle, no motion.
  - cmd_pos_i>pos_o: RUN_FWD. cmd_pos_i<pos_o: RUN_BACK.
  - Home command, home_sw_i=1: pos_o=0, homed_o=1, done_o next cycle.
  - Home command otherwise: HOMING.
- RUN_FWD: move_o=1, back_o=0. Each tick pos_o+1; when the updated pos_o equals target, go to SETTLE.
- RUN_BACK: move_o=1, back_o=1. Each tick pos_o-1; when it equals target, go to SETTLE.
- RUN_BACK, home_sw_i=1 (any cycle) with target not yet reached: pos_o=0, err_o=1, SETTLE.
- HOMING: move_o=1, back_o=1. home_sw_i checked every cycle; when high: pos_o=0, homed_o=1, SETTLE. HOME_TIMEOUT ticks without switch: homed_o=0, err_o=1, SETTLE.
- abort_i in RUN_FWD/RUN_BACK/HOMING: SETTLE next cycle, err_o=1. A tick in the same cycle is still counted. Abort during HOMING clears homed_o. abort_i ignored in IDLE and SETTLE.
- SETTLE: move_o=0; back_o holds its last value. After one tick period (TICK_CYCLES cycles): done_o=1 for one cycle, back_o=0, IDLE.
- cmd_valid_i while busy: ignored (ready low), no side effect.
- pos_o never leaves 0..MAX_POS; RUN_FWD targets are bounded by the accept check.
- All outputs registered except cmd_ready_o and busy_o, which decode the state register.

Decomposition:
- Package track_ctrl_pkg: state enum (IDLE, RUN_FWD, RUN_BACK, HOMING, SETTLE); default TICK_CYCLES and MAX_POS constants.
- Sub-module step_tick_gen: parameter TICK_CYCLES; inputs clk, rst_n, clr; output tick (1-cycle pulse). The controller's homing-timeout counter stays inside the FSM.

Test Plan (TICK_CYCLES=10, MAX_POS=200):
1. Reset, then position command 5 with homed_o=0 -> err_o=1, done_o pulse 1 cycle after accept, move_o never asserted, pos_o=0.
2. Home command, home_sw_i=0, raised 25 cycles later -> move_o=1/back_o=1 until switch, then pos_o=0, homed_o=1, move_o=0, done_o 10 cycles after switch, err_o=0.
3. Homed at 0, position command 4 -> move_o=1/back_o=0 for 40 cycles, pos_o steps 1,2,3,4 every 10 cycles, then 10-cycle settle, done_o, err_o=0.
4. From 4, position command 1 -> back_o=1, 3 ticks, pos_o=1, done_o. Then command 1 again -> done_o next cycle with no motion.
5. From 1, position command 10; abort_i after the 2nd tick -> pos_o=3, err_o=1, move_o low next cycle, done_o after settle. Next accepted command clears err_o.
6. Command 201 -> err_o=1, no motion. Home with switch stuck low -> err_o=1, homed_o=0 after 216 ticks. cmd_valid_i pulsed while busy -> no effect.
